// File: rtl/csv_stream_arbiter.sv
// Frame-granular arbiter sharing one csv_parser between two buffered byte sources.
// Optional statistics outputs are enabled with `define CSV_ARB_STATS_EN.
module csv_stream_arbiter #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s0_char,
   input  logic        s0_val,
   output logic        s0_rdy,
   input  logic [7:0]  s1_char,
   input  logic        s1_val,
   output logic        s1_rdy,
   output logic [7:0]  char_out,
   output logic        char_val,
   output logic        frame_src,
   output logic        frame_abort,
   output logic        busy
`ifdef CSV_ARB_STATS_EN
   ,
   output logic [15:0] frames0,
   output logic [15:0] frames1,
   output logic [7:0]  aborts,
   output logic        overrun
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_ABORT  = 2'd2;
   localparam logic [7:0] LF        = 8'h0A;

   logic [7:0]    mem_q [2][DEPTH];
   logic [AW:0]   wr_q [2];
   logic [AW:0]   rd_q [2];
   logic [7:0]    in_char_s [2];
   logic [7:0]    head_s [2];
   logic [1:0]    in_val_s, empty_s, full_s, push_s, pop_s, elig_s;

   logic [1:0]    state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_q, last_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    resync_q, resync_d;
   logic [7:0]    char_out_q, char_out_d;
   logic          char_val_q, char_val_d;
   logic          abort_q, abort_d;
   logic          busy_q;
   logic          frame_done_s;

   assign in_char_s[0] = s0_char;
   assign in_char_s[1] = s1_char;
   assign in_val_s     = {s1_val, s0_val};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         empty_s[i] = (wr_q[i] == rd_q[i]);
         full_s[i]  = (wr_q[i][AW] != rd_q[i][AW]) &&
                      (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
         head_s[i]  = mem_q[i][rd_q[i][AW-1:0]];
         push_s[i]  = in_val_s[i] && !full_s[i];
      end
   end

   assign s0_rdy = !full_s[0];
   assign s1_rdy = !full_s[1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push_s[i]) begin
            mem_q[i][wr_q[i][AW-1:0]] <= in_char_s[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wr_q[i] <= '0;
            rd_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push_s[i]) wr_q[i] <= wr_q[i] + (AW+1)'(1);
            if (pop_s[i])  rd_q[i] <= rd_q[i] + (AW+1)'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      tmo_d      = tmo_q;
      resync_d   = resync_q;
      char_out_d = char_out_q;
      char_val_d = 1'b0;
      abort_d    = 1'b0;
      pop_s      = 2'b00;
      elig_s     = ~empty_s & ~resync_q;
      case (state_q)
         ST_IDLE: begin
            if (elig_s != 2'b00) begin
               state_d = ST_STREAM;
               tmo_d   = '0;
               grant_d = (elig_s == 2'b11) ? ~last_q : elig_s[1];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (!empty_s[grant_q]) begin
               pop_s[grant_q] = 1'b1;
               char_out_d     = head_s[grant_q];
               char_val_d     = 1'b1;
               tmo_d          = '0;
               if (head_s[grant_q] == LF) begin
                  state_d = ST_IDLE;
                  last_d  = grant_q;
               end else begin
                  state_d = ST_STREAM;
               end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               tmo_d   = TW'(TIMEOUT);
               state_d = ST_ABORT;
            end else begin
               tmo_d   = tmo_q + TW'(1);
            end
         end
         ST_ABORT: begin
            char_out_d        = LF;
            char_val_d        = 1'b1;
            abort_d           = 1'b1;
            resync_d[grant_q] = 1'b1;
            last_d            = grant_q;
            state_d           = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A resyncing source drains up to and including its next '\n' while not granted
      for (int i = 0; i < 2; i++) begin
         if (resync_q[i] && !(state_q != ST_IDLE && grant_q == i[0]) && !empty_s[i]) begin
            pop_s[i] = 1'b1;
            if (head_s[i] == LF) resync_d[i] = 1'b0;
         end
      end
   end

   assign frame_done_s = (state_q == ST_STREAM) && !empty_s[grant_q] && (head_s[grant_q] == LF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         tmo_q      <= '0;
         resync_q   <= 2'b00;
         char_out_q <= 8'h00;
         char_val_q <= 1'b0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         tmo_q      <= tmo_d;
         resync_q   <= resync_d;
         char_out_q <= char_out_d;
         char_val_q <= char_val_d;
         abort_q    <= abort_d;
         busy_q     <= (state_q != ST_IDLE);
      end
   end

   assign char_out    = char_out_q;
   assign char_val    = char_val_q;
   assign frame_abort = abort_q;
   assign frame_src   = grant_q;
   assign busy        = busy_q;

`ifdef CSV_ARB_STATS_EN
   logic [15:0] frames0_q, frames1_q;
   logic [7:0]  aborts_q;
   logic        overrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames0_q <= 16'h0000;
         frames1_q <= 16'h0000;
         aborts_q  <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         if (frame_done_s && !grant_q) frames0_q <= frames0_q + 16'd1;
         if (frame_done_s && grant_q)  frames1_q <= frames1_q + 16'd1;
         if (state_q == ST_ABORT && aborts_q != 8'hFF) aborts_q <= aborts_q + 8'd1;
         if ((s0_val && full_s[0]) || (s1_val && full_s[1])) overrun_q <= 1'b1;
      end
   end

   assign frames0 = frames0_q;
   assign frames1 = frames1_q;
   assign aborts  = aborts_q;
   assign overrun = overrun_q;
`else
   logic unused_s;
   assign unused_s = frame_done_s;
`endif

endmodule

// File: doc/csv_stream_arbiter.md
Name: csv_stream_arbiter

Overview:
- Shares one csv_parser between two independent ASCII byte sources, e.g. two UART receivers from two sensor boards.
- Each source has a small input FIFO.
- Arbitration is frame-granular: once a source is granted, its characters pass to the parser until its '\n' has been forwarded. Frames from different sources are never interleaved.
- A mid-frame stall longer than TIMEOUT cycles aborts the frame and resynchronises that source.

Parameters:
- DEPTH, 16, per-source FIFO depth in characters; power of two, minimum 4.
- TIMEOUT, 50000, maximum idle cycles inside a granted frame before abort; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s0_char  in  8  source 0 character
- s0_val  in  1  source 0 character valid
- s0_rdy  out  1  source 0 ready (FIFO not full)
- s1_char  in  8  source 1 character
- s1_val  in  1  source 1 character valid
- s1_rdy  out  1  source 1 ready
- char_out  out  8  character to parser char_in
- char_val  out  1  one-cycle strobe to parser char_val
- frame_src  out  1  source of the frame currently or last forwarded
- frame_abort  out  1  one-cycle pulse, coincident with the synthetic '\n' of an aborted frame
- busy  out  1  high in STREAM or ABORT

Behaviour:
- Reset (async assert, sync release):
  - FIFOs empty; state IDLE; last-grant = 1, so source 0 wins the first tie.
  - Timeout counter 0; resync flags 0.
  - All outputs 0, except sN_rdy = 1 after reset.
  - Reset mid-frame discards all FIFO contents and any partial frame; no '\n' is emitted.
- FIFO:
  - Push when sN_val && sN_rdy; sN_rdy = !full.
  - A push while full is dropped; the source must honour rdy.
  - Push and pop in the same cycle are allowed at any fill level other than full-push.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- IDLE:
  - Eligible sources have a non-empty FIFO and a clear resync flag.
  - If both are eligible, grant the one not granted last (round-robin). If one is eligible, grant it.
  - Registered grant: go to STREAM next cycle. frame_src updates with the grant.
- STREAM:
  - Each cycle the granted FIFO is non-empty: pop one character. char_out and char_val are registered, so they are valid the cycle after the pop. Clear the timeout counter.
  - When the FIFO is empty: increment the timeout counter.
  - Popped character == 8'h0A: go to IDLE; record last-grant.
  - Counter reaches TIMEOUT: go to ABORT.
  - Minimum gap between frames is one IDLE cycle, so back-to-back frames cost one bubble.
- ABORT (one cycle):
  - Emit char_out = 8'h0A, char_val = 1, frame_abort = 1.
  - Set resync[granted], record last-grant, go to IDLE.
  - Downstream treats the parser frame_done of that cycle+1 as invalid.
- Resync:
  - While resync[s] is set and s is not granted, pop and discard one character from s per cycle, with no output.
  - Clear resync[s] when the discarded character is '\n'. The next frame from s is then clean.
  - An empty FIFO simply waits.
- Non-granted, non-resync sources only buffer; full FIFOs backpressure via rdy.
- char_val is never high on two sources' characters within one frame; throughput is at most 1 character per cycle.
- frame_abort is only ever high together with char_val.

Optional Feature:
- Macro: CSV_ARB_STATS_EN.
- When defined, add outputs:
  - frames0 / frames1 (16 b): completed frames per source; wrap at 0xFFFF.
  - aborts (8 b): saturates at 0xFF.
  - overrun (1 b): sticky; set when sN_val arrives while !sN_rdy.
  - All reset to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Source 0 sends "1,2,3;4,5,6,7,8,1\n" and source 1 is idle → 18 chars on char_out in order, frame_src = 0, frame_abort never set, busy falls one cycle after the '\n' strobe.
- Both FIFOs preloaded with one frame each, arbiter released simultaneously → source 0 frame fully, then source 1 frame fully, no interleaving. Repeat → order alternates 0,1,0,1.
- Source 1 pushes 20 chars while source 0 holds a long frame, DEPTH = 16 → s1_rdy low after 16 chars, none lost once the source honours rdy; the source 1 frame is forwarded intact afterwards.
- TIMEOUT = 10, source 0 sends "12,3" then stalls → after 10 idle cycles a single '\n' with frame_abort = 1. Late "4,5\n" from source 0 is discarded silently. The next "9\n" is forwarded normally.
- Assert rst_n low mid-frame with 5 chars buffered → all outputs 0 immediately; after release, FIFOs are empty and a new frame from source 1 is granted first only if source 0 is empty.
- CSV_ARB_STATS_EN defined: 3 good frames from source 0, 1 from source 1, 1 timeout → frames0 = 3, frames1 = 1, aborts = 1, overrun = 0.
